// File: rtl/maria_bus_arbiter.sv
// Bus arbiter: shares the system address bus between the 6502 and two DMA masters
// (Maria list fetch, debug/savestate port) and sequences the CPU halt handshake.
//
// Ports:
//   sysclk      - system clock, all state on rising edge
//   reset       - synchronous, active-high
//   enable      - Maria DMA enable; low forces the bus back to the CPU
//   cpu_phi_ok  - high in cycles where halt_b is allowed to rise
//   req_maria   - Maria level request (high for whole access, drop = done)
//   req_dbg     - debug port level request
//   cpu_addr    - CPU address
//   maria_addr  - Maria DMA address
//   dbg_addr    - debug port address
//   halt_b      - CPU halt, active-low, registered
//   gnt_maria   - Maria owns the bus, registered
//   gnt_dbg     - debug port owns the bus, registered
//   bus_sel     - 0=CPU 1=Maria 2=debug 3=none, registered
//   bus_addr    - address selected by bus_sel, 0 on a dead cycle
//   busy        - high whenever the arbiter is not idle
module maria_bus_arbiter #(
    parameter int HALT_LATENCY = 9,
    parameter int COOLDOWN     = 1,
    parameter int ADDR_W       = 16
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              enable,
    input  logic              cpu_phi_ok,
    input  logic              req_maria,
    input  logic              req_dbg,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [ADDR_W-1:0] maria_addr,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              halt_b,
    output logic              gnt_maria,
    output logic              gnt_dbg,
    output logic [1:0]        bus_sel,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              busy
);

    localparam int CTR_MAX = (HALT_LATENCY > COOLDOWN) ? HALT_LATENCY : COOLDOWN;
    localparam int CTR_W   = (CTR_MAX > 0) ? $clog2(CTR_MAX + 1) : 1;

    localparam logic [1:0] SEL_CPU   = 2'd0;
    localparam logic [1:0] SEL_MARIA = 2'd1;
    localparam logic [1:0] SEL_DBG   = 2'd2;
    localparam logic [1:0] SEL_NONE  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT_WAIT,
        S_GRANT,
        S_HANDOFF,
        S_COOLDOWN,
        S_RELEASE_WAIT
    } state_e;

    state_e           state_q;
    logic [CTR_W-1:0] ctr_q;
    logic             halt_b_q;
    logic             gnt_maria_q;
    logic             gnt_dbg_q;
    logic [1:0]       bus_sel_q;
    // 1 = debug port was the most recent owner, 0 = Maria.
    logic             last_dbg_q;

    logic owner_req;
    logic other_req;
    logic pick_dbg;

    // The current owner is always last_dbg_q, since it is updated at every grant.
    always_comb begin
        owner_req = last_dbg_q ? req_dbg   : req_maria;
        other_req = last_dbg_q ? req_maria : req_dbg;
        // Lone requester wins; on contention the non-last owner wins.
        pick_dbg  = req_dbg & (~req_maria | ~last_dbg_q);
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ctr_q       <= '0;
            halt_b_q    <= 1'b1;
            gnt_maria_q <= 1'b0;
            gnt_dbg_q   <= 1'b0;
            bus_sel_q   <= SEL_CPU;
            last_dbg_q  <= 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    bus_sel_q <= SEL_CPU;
                    if (enable && (req_maria || req_dbg)) begin
                        halt_b_q <= 1'b0;
                        ctr_q    <= CTR_W'(1);
                        state_q  <= S_HALT_WAIT;
                    end
                end

                S_HALT_WAIT: begin
                    if (!enable || (!req_maria && !req_dbg)) begin
                        bus_sel_q <= SEL_CPU;
                        ctr_q     <= CTR_W'(COOLDOWN);
                        state_q   <= S_COOLDOWN;
                    end else if (ctr_q == CTR_W'(HALT_LATENCY)) begin
                        gnt_maria_q <= ~pick_dbg;
                        gnt_dbg_q   <= pick_dbg;
                        bus_sel_q   <= pick_dbg ? SEL_DBG : SEL_MARIA;
                        last_dbg_q  <= pick_dbg;
                        state_q     <= S_GRANT;
                    end else begin
                        ctr_q <= ctr_q + CTR_W'(1);
                    end
                end

                S_GRANT: begin
                    if (!enable || !owner_req) begin
                        gnt_maria_q <= 1'b0;
                        gnt_dbg_q   <= 1'b0;
                        if (enable && other_req) begin
                            // One dead cycle between owners, CPU stays halted.
                            bus_sel_q <= SEL_NONE;
                            state_q   <= S_HANDOFF;
                        end else begin
                            bus_sel_q <= SEL_CPU;
                            ctr_q     <= CTR_W'(COOLDOWN);
                            state_q   <= S_COOLDOWN;
                        end
                    end
                end

                S_HANDOFF: begin
                    if (!enable || !other_req) begin
                        bus_sel_q <= SEL_CPU;
                        ctr_q     <= CTR_W'(COOLDOWN);
                        state_q   <= S_COOLDOWN;
                    end else begin
                        gnt_maria_q <= last_dbg_q;
                        gnt_dbg_q   <= ~last_dbg_q;
                        bus_sel_q   <= last_dbg_q ? SEL_MARIA : SEL_DBG;
                        last_dbg_q  <= ~last_dbg_q;
                        state_q     <= S_GRANT;
                    end
                end

                S_COOLDOWN: begin
                    bus_sel_q <= SEL_CPU;
                    // A zero cooldown still spends this one cycle here.
                    if (ctr_q <= CTR_W'(1)) begin
                        state_q <= S_RELEASE_WAIT;
                    end
                    if (ctr_q != '0) begin
                        ctr_q <= ctr_q - CTR_W'(1);
                    end
                end

                S_RELEASE_WAIT: begin
                    bus_sel_q <= SEL_CPU;
                    if (cpu_phi_ok) begin
                        halt_b_q <= 1'b1;
                        state_q  <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        unique case (bus_sel_q)
            SEL_CPU:   bus_addr = cpu_addr;
            SEL_MARIA: bus_addr = maria_addr;
            SEL_DBG:   bus_addr = dbg_addr;
            default:   bus_addr = '0;
        endcase
    end

    assign halt_b    = halt_b_q;
    assign gnt_maria = gnt_maria_q;
    assign gnt_dbg   = gnt_dbg_q;
    assign bus_sel   = bus_sel_q;
    assign busy      = (state_q != S_IDLE);

endmodule
